// File: rtl/stream_rx_fifo.sv
// Receive-side stream FIFO: accepts words on a 32-bit valid/ready port and re-presents them in order.
// Optional occupancy statistics are enabled with the STREAM_RX_FIFO_STATS_EN macro.
module stream_rx_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef STREAM_RX_FIFO_STATS_EN
    output logic [31:0]           stat_accepted,
    output logic [31:0]           stat_stalled,
`endif
    output logic [CNT_W-1:0]      count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [AW-1:0]    PTR_ONE = AW'(1);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  full_r;
    logic                  nonempty_r;

    logic                  push_s;
    logic                  pop_s;
    logic [CNT_W-1:0]      count_nxt_s;

    // Handshake flags come from registered state only; reset masks them directly.
    assign in_ready  = rst_ni & ~full_r;
    assign out_valid = rst_ni & nonempty_r;
    assign out_data  = mem_r[rd_ptr_r];
    assign count     = count_r;

    assign push_s = in_valid & in_ready;
    assign pop_s  = out_valid & out_ready;

    // Next occupancy: push and pop in the same cycle cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            2'b11:   count_nxt_s = count_r;
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage write port; contents are intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Pointers, occupancy and the registered full/non-empty flags.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            full_r     <= 1'b0;
            nonempty_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r    <= count_nxt_s;
            full_r     <= (count_nxt_s == DEPTH_C);
            nonempty_r <= (count_nxt_s != {CNT_W{1'b0}});
        end
    end

`ifdef STREAM_RX_FIFO_STATS_EN
    logic [31:0] stat_accepted_r;
    logic [31:0] stat_stalled_r;
    logic        stall_s;

    assign stall_s       = in_valid & ~in_ready & rst_ni;
    assign stat_accepted = stat_accepted_r;
    assign stat_stalled  = stat_stalled_r;

    // Saturating event counters; they stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stat_accepted_r <= 32'h0000_0000;
            stat_stalled_r  <= 32'h0000_0000;
        end else begin
            if (push_s && (stat_accepted_r != 32'hFFFF_FFFF)) begin
                stat_accepted_r <= stat_accepted_r + 32'h0000_0001;
            end
            if (stall_s && (stat_stalled_r != 32'hFFFF_FFFF)) begin
                stat_stalled_r <= stat_stalled_r + 32'h0000_0001;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stream_rx_fifo.sv
// Directed and randomized bench for stream_rx_fifo, checked against a queue-based reference model.
module tb_stream_rx_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [31:0]       in_data;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
`ifdef STREAM_RX_FIFO_STATS_EN
    logic [31:0]       stat_accepted;
    logic [31:0]       stat_stalled;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] model_q[$];
    longint unsigned m_acc = 0;
    longint unsigned m_stall = 0;
    int pushes_total = 0;

    always #5 clk_i = ~clk_i;

    stream_rx_fifo #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef STREAM_RX_FIFO_STATS_EN
        .stat_accepted (stat_accepted),
        .stat_stalled  (stat_stalled),
`endif
        .count     (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check pre-edge outputs against the model, advance the model.
    task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic rn);
        logic exp_ir;
        logic exp_ov;
        logic do_push;
        logic do_pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        rst_ni    = rn;
        #1;
        exp_ir = rn && (model_q.size() < DEPTH);
        exp_ov = rn && (model_q.size() > 0);
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("count", 32'(count), 32'(model_q.size()));
        if (exp_ov) begin
            chk("out_data", out_data, model_q[0]);
        end
`ifdef STREAM_RX_FIFO_STATS_EN
        chk("stat_accepted", stat_accepted, 32'(m_acc));
        chk("stat_stalled", stat_stalled, 32'(m_stall));
`endif
        do_push = v && exp_ir;
        do_pop  = r && exp_ov;
        @(posedge clk_i);
        if (!rn) begin
            model_q.delete();
            m_acc = 0;
            m_stall = 0;
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                model_q.push_back(d);
                m_acc++;
                pushes_total++;
            end
            if (v && !exp_ir) m_stall++;
        end
        @(negedge clk_i);
    endtask

    initial begin
        int cyc;
        int start_pushes;
        rst_ni    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0000_0000;
        out_ready = 1'b0;
        // Two reset cycles before any check: state is unknown before the first edge.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);

        // Idle after reset.
        cycle(1'b0, 32'h0000_0000, 1'b0, 1'b1);
        chk("reset_count", 32'(count), 32'h0000_0000);

        // Single word with a held-off consumer, then one pop.
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        chk("single_data", out_data, 32'hDEAD_BEEF);
        cycle(1'b0, 32'h0000_0000, 1'b1, 1'b1);
        cycle(1'b0, 32'h0000_0000, 1'b0, 1'b1);

        // Fill, then pop while full with a pending word.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b0, 1'b1);
        chk("fill_count", 32'(count), 32'h0000_0004);
        chk("fill_in_ready", 32'(in_ready), 32'h0000_0000);
        cycle(1'b1, 32'h0000_0005, 1'b1, 1'b1);
        cycle(1'b1, 32'h0000_0005, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0000_0000, 1'b1, 1'b1);
        chk("drain_empty", 32'(out_valid), 32'h0000_0000);

        // Back-to-back streaming across pointer wrap.
        for (int i = 0; i < 20; i++) cycle(1'b1, 32'(i), 1'b1, 1'b1);
        cycle(1'b0, 32'h0000_0000, 1'b1, 1'b1);

        // Random stalls on both sides, bounded by a cycle budget.
        start_pushes = pushes_total;
        cyc = 0;
        while ((pushes_total - start_pushes) < 200 && cyc < 4000) begin
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b1);
            cyc++;
        end
        chk("random_budget", 32'(pushes_total - start_pushes), 32'd200);
        cyc = 0;
        while (model_q.size() > 0 && cyc < 100) begin
            cycle(1'b0, 32'h0000_0000, 1'($urandom_range(0, 1)), 1'b1);
            cyc++;
        end
        cycle(1'b0, 32'h0000_0000, 1'b0, 1'b1);

        // Fill then stall three cycles, then reset mid-stream.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hBBBB_0000, 1'b0, 1'b1);
        cycle(1'b0, 32'h0000_0000, 1'b1, 1'b0);
        cycle(1'b0, 32'h0000_0000, 1'b0, 1'b1);

        // Reset with count=3 and a consumer/producer active in the reset cycle.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b1);
        chk("pre_reset_count", 32'(count), 32'h0000_0003);
        cycle(1'b1, 32'hCCCC_CCCC, 1'b1, 1'b0);
        chk("post_reset_count", 32'(count), 32'h0000_0000);
        cycle(1'b1, 32'h1234_5678, 1'b0, 1'b1);
        cycle(1'b0, 32'h0000_0000, 1'b1, 1'b1);
        cycle(1'b0, 32'h0000_0000, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stream_rx_fifo.md
Name: stream_rx_fifo

Overview:
- Receiving end of the 32-bit data/valid/ready stream interface (`data`, `valid`, `ready` bundle used by the interface instances).
- Acts as the responder: drives `ready` and accepts words from an upstream producer.
- Buffers accepted words in a small circular FIFO and re-presents them in order on a downstream valid/ready port.
- Decouples producer timing from the consumer; placed at every interface sink that cannot accept data unconditionally.

Parameters:
- DATA_WIDTH, 32, width of the data field; matches the interface `data` field.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count; derived, do not override.

Ports:
- clk_i  in  1  sole clock; all state updates on rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- in_data  in  DATA_WIDTH  upstream payload.
- in_valid  in  1  upstream word present.
- in_ready  out  1  block can accept a word this cycle.
- out_data  out  DATA_WIDTH  head-of-FIFO payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head this cycle.
- count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_ni=0 at a clock edge):
  - wr_ptr, rd_ptr, count := 0.
  - From the following cycle: out_valid=0, in_ready=1.
  - While rst_ni is low: in_ready forced to 0, out_valid forced to 0.
  - Storage array is not reset.
- Push: fires when in_valid && in_ready.
  - mem[wr_ptr] := in_data; wr_ptr := wr_ptr+1 mod DEPTH.
- Pop: fires when out_valid && out_ready.
  - rd_ptr := rd_ptr+1 mod DEPTH.
- in_ready = (count != DEPTH).
  - Depends on registered state only; no combinational path from out_ready or in_valid.
  - Full with a simultaneous pop: no push that cycle; in_ready rises the next cycle.
- out_valid = (count != 0).
  - out_data = mem[rd_ptr], combinational from storage.
  - out_data is don't-care while out_valid=0.
- Latency: a word pushed in cycle N is visible on out_valid/out_data in cycle N+1. No fall-through or bypass.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
  - Never exceeds DEPTH; never underflows.
- Simultaneous push and pop at count=1: the new word becomes head in the next cycle; count stays 1.
- Empty with in_valid high: word accepted; out_valid=1 next cycle.
- Pointers wrap silently at DEPTH; ordering strictly FIFO across wrap.
- Downstream may deassert out_ready at any time: out_data/out_valid hold stable until popped.
- Upstream obligations (not checked by the block): in_data stable while in_valid && !in_ready; in_valid not withdrawn before acceptance.
- Reset mid-operation: all buffered words are discarded; count=0 next cycle; no partial pop or push completes in the reset cycle.

Optional Feature:
- Macro: STREAM_RX_FIFO_STATS_EN.
- When defined, two output ports are added:
  - stat_accepted  out  32: count of pushes.
  - stat_stalled  out  32: count of cycles with in_valid && !in_ready && rst_ni.
  - Both reset to 0 synchronously and saturate at 32'hFFFF_FFFF (no wrap).
- When undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- Reset then idle: hold rst_ni=0 for 2 cycles, release -> first cycle after release in_ready=1, out_valid=0, count=0.
- Single word: push 32'hDEAD_BEEF with out_ready=0 -> next cycle out_valid=1, out_data=32'hDEAD_BEEF, count=1; assert out_ready one cycle -> count=0, out_valid=0.
- Fill and backpressure (DEPTH=4): push 1,2,3,4 with out_ready=0 -> count=4, in_ready=0. Then hold in_valid=1 with data 5 and out_ready=1 -> cycle 1 pops 1 with no push; cycle 2 accepts 5; output order 1,2,3,4,5.
- Wrap-around streaming: 20 consecutive words 0..19, in_valid=out_ready=1 every cycle -> in_ready stays 1, count stays 1 after first cycle, outputs 0..19 in order, each one cycle after input.
- Random stalls: 200 words, in_valid and out_ready each random 50% -> output sequence equals input sequence; count always equals pushes minus pops and stays within 0..4.
- Reset mid-stream: with count=3, drive rst_ni=0 one cycle -> next cycle count=0, out_valid=0. With STREAM_RX_FIFO_STATS_EN, a 3-cycle full stall gives stat_stalled=3 and both counters read 0 after reset.
